seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Sequential signed radix-2 restoring divider: the inverse operation of shift_mult in the
//  arithmetic calculator datapath. Accepts WIDTH-bit dividend/divisor on a start pulse,
//  iterates one quotient bit per clock, then returns quotient and remainder with a one-cycle
//  done pulse. Sits beside shift_mult under the calculator's operation select.
// PARAMETERS
//  WIDTH   32   operand, quotient and remainder width (two's complement); WIDTH >= 4
// PORTS
//  clk          in   1      rising-edge clock; single clock domain
//  reset        in   1      asynchronous, active-high; forces IDLE and clears all outputs
//  start        in   1      request; sampled only when busy=0
//  dividend     in   WIDTH  signed numerator, captured on accepted start
//  divisor      in   WIDTH  signed denominator, captured on accepted start
//  quotient     out  WIDTH  signed result, truncated toward zero
//  remainder    out  WIDTH  signed remainder, sign follows dividend
//  busy         out  1      high from the accepting edge until done is asserted
//  done         out  1      one-cycle pulse; quotient/remainder valid from this cycle on
//  div_by_zero  out  1      set with done when divisor==0; held until next accepted start
//  overflow     out  1      set with done for MIN/-1; held until next accepted start
// BEHAVIOUR
//  Reset: state=IDLE; quotient, remainder, busy, done, div_by_zero, overflow all 0.
//  States: IDLE -> CALC -> FIX -> IDLE; IDLE -> ZDIV -> IDLE for divisor==0.
//  IDLE: on edge with start=1: latch |dividend|, |divisor|, sign_q=dividend[MSB]^divisor[MSB],
//   sign_r=dividend[MSB]; clear flags; busy=1; count=0; go CALC (or ZDIV if divisor==0).
//  CALC: per edge, {rem,quo} shifted left 1; trial = rem - |divisor| (WIDTH+1 bits);
//   if trial >= 0 then rem=trial, quo[0]=1 else quo[0]=0; count++; after count==WIDTH-1 -> FIX.
//  FIX: apply signs (negate quo if sign_q, rem if sign_r); drive outputs; done=1, busy=0; -> IDLE.
//  Latency: start sampled at edge 0; done high after edge WIDTH+1 (33 for WIDTH=32), 1 cycle.
//  ZDIV: quotient=all ones, remainder=dividend, div_by_zero=1, done=1 after edge 1, busy=0.
//  Overflow: dividend=MIN, divisor=-1 -> quotient=MIN, remainder=0, overflow=1; normal latency.
//  Magnitude of MIN taken as unsigned 2^(WIDTH-1) (WIDTH+1-bit internal regs; no wrap).
//  start while busy=1: ignored; operand changes after acceptance: no effect.
//  start in the done cycle: accepted (state is IDLE); new op begins, outputs hold until its done.
//  quotient/remainder hold last result between operations; done is never held high.
//  reset asserted mid-operation: immediate return to IDLE, outputs 0, no done pulse.
// STRUCTURE
//  calc_pkg: state enum {IDLE, CALC, FIX, ZDIV}; localparams for MIN value and counter width
//   $clog2(WIDTH); shared with shift_mult control.
//  Sub-module div_step: combinational single restoring step
//   (rem_in, quo_in, divisor -> rem_out, quo_out); instantiated once, driven by the FSM.
//  Counter, sign latches and result registers stay in the top-level seq_divider.
// TESTING
//  100 / 7 -> quotient=14, remainder=2, flags 0, done exactly 33 edges after start edge.
//  -100 / 7 -> quotient=-14 (0xFFFFFFF2), remainder=-2 (0xFFFFFFFE).
//  7 / 0 -> quotient=0xFFFFFFFF, remainder=7, div_by_zero=1, done 1 edge after start.
//  0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, overflow=1.
//  start pulsed at count=5 with new operands -> ignored; first result 100/7 unchanged;
//   reset at count=10 -> busy=0, outputs 0, no done.
//  Back-to-back: start held high through done -> second op accepted that cycle, 1000/-3 ->
//   quotient=-333, remainder=1; plus 1000 random signed pairs vs $signed / and %.

Source files
------------

// File: rtl/calc_pkg.sv
// +----------------------------------------------------------------------+
// | calc_pkg : state encoding and width constants shared by the          |
// |            calculator datapath control (seq_divider, shift_mult)     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package calc_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);
  localparam logic [DIV_WIDTH-1:0] DIV_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

  typedef logic [1:0] calc_state_t;

  localparam calc_state_t ST_IDLE = 2'd0;
  localparam calc_state_t ST_CALC = 2'd1;
  localparam calc_state_t ST_FIX  = 2'd2;
  localparam calc_state_t ST_ZDIV = 2'd3;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// +----------------------------------------------------------------------+
// | div_step : one combinational radix-2 restoring step on magnitudes    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH:0]   dvsr_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_trial;

  // Extra top bit keeps the trial subtraction sign exact for a 2^(WIDTH-1) divisor.
  assign w_shift = {rem_i, quo_i[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, dvsr_i};

  always_comb begin
    rem_o = w_trial[WIDTH:0];
    quo_o = {quo_i[WIDTH-2:0], 1'b1};
    if (w_trial[WIDTH+1]) begin
      rem_o = w_shift[WIDTH:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// +----------------------------------------------------------------------+
// | seq_divider : sequential signed restoring divider, one bit per clock |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module seq_divider
  import calc_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  calc_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH:0]   dvsr_q, dvsr_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] w_abs_dvd;
  logic [WIDTH-1:0] w_abs_dvs;
  logic [WIDTH:0]   w_step_rem;
  logic [WIDTH-1:0] w_step_quo;

  // Unsigned magnitude: MIN maps to 2^(WIDTH-1) without wrapping.
  assign w_abs_dvd = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign w_abs_dvs = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (w_step_rem),
    .quo_o  (w_step_quo)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    ovf_pend_d  = ovf_pend_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d      = '0;
          quo_d      = w_abs_dvd;
          dvsr_d     = {1'b0, w_abs_dvs};
          neg_quo_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_rem_d  = dividend[WIDTH-1];
          ovf_pend_d = (dividend == MIN_VAL) && (divisor == '1);
          dbz_d      = 1'b0;
          ovf_d      = 1'b0;
          busy_d     = 1'b1;
          cnt_d      = '0;
          state_d    = (divisor == '0) ? ST_ZDIV : ST_CALC;
        end
      end
      ST_CALC: begin
        rem_d = w_step_rem;
        quo_d = w_step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        quotient_d  = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
        remainder_d = neg_rem_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
        ovf_d       = ovf_pend_q;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
      ST_ZDIV: begin
        // quo_q still holds |dividend|; re-signing it returns the dividend as remainder.
        quotient_d  = '1;
        remainder_d = neg_rem_q ? (~quo_q + 1'b1) : quo_q;
        dbz_d       = 1'b1;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      ovf_pend_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      ovf_pend_q  <= ovf_pend_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// +----------------------------------------------------------------------+
// | tb_seq_divider : scoreboard bench for seq_divider (WIDTH = 32)       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_seq_divider;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic        overflow;

  int   n_checks;
  int   n_errors;
  int   cyc;
  exp_t sb[$];

  seq_divider #(
    .WIDTH (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] q, input logic [31:0] r,
                              input logic dbz, input logic ovf, input int lat);
    exp_t e;
    e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  function automatic exp_t model(input logic signed [31:0] a, input logic signed [31:0] b);
    exp_t e;
    if (b == 0)
      e = mk(32'hFFFF_FFFF, a, 1'b1, 1'b0, 1);
    else if (a == 32'sh8000_0000 && b == -32'sd1)
      e = mk(32'h8000_0000, 32'h0, 1'b0, 1'b1, 33);
    else
      e = mk(a / b, a % b, 1'b0, 1'b0, 33);
    return e;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input exp_t e);
    exp_t x;
    x = e;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    x.acc    = cyc + 1;
    sb.push_back(x);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Scoreboard monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        chk("overflow", 32'(overflow), 32'(e.ovf));
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;

    issue(32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0, 1'b0, 33));
    chk("busy_after_accept", 32'(busy), 32'd1);
    wait_idle();
    issue(-32'sd100, 32'd7, mk(32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, 33));
    wait_idle();
    issue(32'd7, 32'd0, mk(32'hFFFF_FFFF, 32'd7, 1'b1, 1'b0, 1));
    wait_idle();
    issue(32'h8000_0000, 32'hFFFF_FFFF, mk(32'h8000_0000, 32'd0, 1'b0, 1'b1, 33));
    wait_idle();
    issue(32'h8000_0000, 32'd0, mk(32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1));
    wait_idle();
    issue(32'h8000_0000, 32'd1, mk(32'h8000_0000, 32'd0, 1'b0, 1'b0, 33));
    wait_idle();

    // Start pulse mid-operation with new operands must be ignored.
    issue(32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0, 1'b0, 33));
    repeat (4) @(negedge clk);
    dividend = 32'd5;
    divisor  = 32'd1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset mid-operation: outputs clear, no done afterwards.
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_quotient", quotient, 32'd0);
    chk("midrst_remainder", remainder, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_idle_busy", 32'(busy), 32'd0);

    // Back-to-back: start held high through done, second op accepted in the done cycle.
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    begin
      exp_t e;
      e = mk(32'd14, 32'd2, 1'b0, 1'b0, 33);
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    dividend = 32'd1000;
    divisor  = 32'hFFFF_FFFD;
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    chk("b2b_first_done", 32'(done), 32'd1);
    begin
      exp_t e;
      e = mk(32'hFFFF_FEB3, 32'd1, 1'b0, 1'b0, 33);
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    chk("b2b_second_busy", 32'(busy), 32'd1);
    wait_idle();

    for (int i = 0; i < 1000; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2: b = 32'($signed($urandom_range(0, 40)) - 20);
        3:       b = b >> $urandom_range(1, 30);
        4:       a = 32'h8000_0000;
        5:       a = a >> $urandom_range(1, 30);
        default: ;
      endcase
      issue(a, b, model(a, b));
      wait_idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
